// File: rtl/axi_pkg.sv
// AXI channel typedefs, widths and encodings shared by the memory subordinate.
package axi_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [2:0] AXI_BEAT_SIZE = 3'd3;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
  } axi_aw_t;

  typedef axi_aw_t axi_ar_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } axi_r_t;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

  function automatic logic axi_req_illegal(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_BEAT_SIZE) || (burst == AXI_BURST_WRAP);
  endfunction

endpackage

// File: rtl/axi_mem_sub_ram.sv
// Word memory with byte-enable write port and registered read port.
// Words not written since reset read back as zero when INIT_ZERO is set.
module axi_mem_sub_ram
  import axi_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int INIT_ZERO = 1,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [IDX_W-1:0]          widx,
  input  logic [AXI_DATA_WIDTH-1:0] wdata,
  input  logic [AXI_STRB_WIDTH-1:0] wstrb,
  input  logic                      re,
  input  logic [IDX_W-1:0]          ridx,
  output logic [AXI_DATA_WIDTH-1:0] rdata
);

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]          written;
  logic                      wr_valid;
  logic                      rd_valid;

  assign wr_valid = (INIT_ZERO == 0) || written[widx];
  assign rd_valid = (INIT_ZERO == 0) || written[ridx];

  // First write to a fresh word zero-fills the unstrobed bytes.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (wstrb[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        else if (!wr_valid) mem[widx][b*8 +: 8] <= 8'h00;
      end
    end
    if (re) rdata <= rd_valid ? mem[ridx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) written <= '0;
    else if (we) written[widx] <= 1'b1;
  end

endmodule

// File: rtl/axi_mem_sub.sv
// AXI subordinate backed by axi_mem_sub_ram: one outstanding read and one outstanding write.
// state   | meaning
// WR_IDLE | awready high, waiting for a write address
// WR_DATA | wready high, consuming beats until wlast
// WR_RESP | bvalid high until bready
// RD_IDLE | arready high, waiting for a read address
// RD_WAIT | counting down the read latency
// RD_DATA | rvalid high, streaming beats until the last handshake
module axi_mem_sub
  import axi_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  axi_aw_t i_axi_s_aw,
  output logic    o_axi_s_awready,
  input  logic    i_axi_s_awvalid,
  input  axi_w_t  i_axi_s_w,
  output logic    o_axi_s_wready,
  input  logic    i_axi_s_wvalid,
  output axi_b_t  o_axi_s_b,
  input  logic    i_axi_s_bready,
  output logic    o_axi_s_bvalid,
  input  axi_ar_t i_axi_s_ar,
  output logic    o_axi_s_arready,
  input  logic    i_axi_s_arvalid,
  output axi_r_t  o_axi_s_r,
  input  logic    i_axi_s_rready,
  output logic    o_axi_s_rvalid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  wr_state_t                 wr_state;
  logic [AXI_ID_WIDTH-1:0]   wr_id;
  logic [IDX_W-1:0]          wr_idx;
  logic [7:0]                wr_len;
  logic                      wr_fixed;
  logic                      wr_err;
  logic [8:0]                wr_cnt;
  logic                      w_hs;
  logic                      wr_in_range;
  logic                      mem_we;

  rd_state_t                 rd_state;
  logic [AXI_ID_WIDTH-1:0]   rd_id;
  logic [IDX_W-1:0]          rd_idx;
  logic [7:0]                rd_len;
  logic                      rd_fixed;
  logic                      rd_err;
  logic [7:0]                rd_cnt;
  logic [LAT_W-1:0]          lat_cnt;
  logic                      rd_load;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic                      r_zero;
  logic [AXI_DATA_WIDTH-1:0] ram_rdata;
  logic                      unused_ok;

  assign w_hs        = o_axi_s_wready && i_axi_s_wvalid;
  assign wr_in_range = wr_cnt <= {1'b0, wr_len};
  assign mem_we      = w_hs && wr_in_range && !wr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state        <= WR_IDLE;
      o_axi_s_awready <= 1'b0;
      o_axi_s_wready  <= 1'b0;
      o_axi_s_bvalid  <= 1'b0;
      o_axi_s_b       <= '0;
      wr_id           <= '0;
      wr_idx          <= '0;
      wr_len          <= '0;
      wr_fixed        <= 1'b0;
      wr_err          <= 1'b0;
      wr_cnt          <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          o_axi_s_awready <= 1'b1;
          if (o_axi_s_awready && i_axi_s_awvalid) begin
            o_axi_s_awready <= 1'b0;
            o_axi_s_wready  <= 1'b1;
            wr_id           <= i_axi_s_aw.id;
            wr_idx          <= i_axi_s_aw.addr[3 +: IDX_W];
            wr_len          <= i_axi_s_aw.len;
            wr_fixed        <= i_axi_s_aw.burst == AXI_BURST_FIXED;
            wr_err          <= axi_req_illegal(i_axi_s_aw.size, i_axi_s_aw.burst);
            wr_cnt          <= '0;
            wr_state        <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            // Count saturates at len+1 so overrun beats never re-enter range.
            if (wr_in_range) begin
              wr_cnt <= wr_cnt + 9'd1;
              if (!wr_fixed) wr_idx <= wr_idx + IDX_W'(1);
            end
            if (i_axi_s_w.last) begin
              o_axi_s_wready <= 1'b0;
              o_axi_s_bvalid <= 1'b1;
              o_axi_s_b.id   <= wr_id;
              o_axi_s_b.resp <= (wr_err || (wr_cnt != {1'b0, wr_len})) ? AXI_RESP_SLVERR
                                                                       : AXI_RESP_OKAY;
              wr_state       <= WR_RESP;
            end else if (wr_cnt >= {1'b0, wr_len}) begin
              wr_err <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (i_axi_s_bready) begin
            o_axi_s_bvalid <= 1'b0;
            wr_state       <= WR_IDLE;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  assign rd_load = ((rd_state == RD_WAIT) && (lat_cnt == '0)) ||
                   ((rd_state == RD_DATA) && o_axi_s_rvalid && i_axi_s_rready && !r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state        <= RD_IDLE;
      o_axi_s_arready <= 1'b0;
      o_axi_s_rvalid  <= 1'b0;
      rd_id           <= '0;
      rd_idx          <= '0;
      rd_len          <= '0;
      rd_fixed        <= 1'b0;
      rd_err          <= 1'b0;
      rd_cnt          <= '0;
      lat_cnt         <= '0;
      r_id            <= '0;
      r_resp          <= '0;
      r_last          <= 1'b0;
      r_zero          <= 1'b1;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          o_axi_s_arready <= 1'b1;
          if (o_axi_s_arready && i_axi_s_arvalid) begin
            o_axi_s_arready <= 1'b0;
            rd_id           <= i_axi_s_ar.id;
            rd_idx          <= i_axi_s_ar.addr[3 +: IDX_W];
            rd_len          <= i_axi_s_ar.len;
            rd_fixed        <= i_axi_s_ar.burst == AXI_BURST_FIXED;
            rd_err          <= axi_req_illegal(i_axi_s_ar.size, i_axi_s_ar.burst);
            rd_cnt          <= '0;
            lat_cnt         <= LAT_W'(READ_LATENCY - 1);
            rd_state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
        end
        RD_DATA: begin
          if (o_axi_s_rvalid && i_axi_s_rready && r_last) begin
            o_axi_s_rvalid <= 1'b0;
            rd_state       <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
      // The RAM read port fires on this same edge, so r_* and ram_rdata stay aligned.
      if (rd_load) begin
        o_axi_s_rvalid <= 1'b1;
        r_id           <= rd_id;
        r_resp         <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        r_last         <= rd_cnt == rd_len;
        r_zero         <= rd_err;
        rd_cnt         <= rd_cnt + 8'd1;
        if (!rd_fixed) rd_idx <= rd_idx + IDX_W'(1);
        rd_state       <= RD_DATA;
      end
    end
  end

  always_comb begin
    o_axi_s_r      = '0;
    o_axi_s_r.id   = r_id;
    o_axi_s_r.data = r_zero ? '0 : ram_rdata;
    o_axi_s_r.resp = r_resp;
    o_axi_s_r.last = r_last;
  end

  axi_mem_sub_ram #(
    .DEPTH     (DEPTH),
    .INIT_ZERO (INIT_ZERO)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .widx  (wr_idx),
    .wdata (i_axi_s_w.data),
    .wstrb (i_axi_s_w.strb),
    .re    (rd_load),
    .ridx  (rd_idx),
    .rdata (ram_rdata)
  );

  assign unused_ok = ^{i_axi_s_w.id,
                       i_axi_s_aw.addr[2:0], i_axi_s_aw.addr[AXI_ADDR_WIDTH-1:3+IDX_W],
                       i_axi_s_ar.addr[2:0], i_axi_s_ar.addr[AXI_ADDR_WIDTH-1:3+IDX_W]};

endmodule

// File: tb/tb_axi_mem_sub.sv
// Directed bench for axi_mem_sub: reset, single beats, strobes, wrapping bursts,
// R back-pressure, same-edge collision and illegal requests.
module tb_axi_mem_sub;
  import axi_pkg::*;

  localparam int DEPTH        = 1024;
  localparam int READ_LATENCY = 1;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  axi_aw_t aw = '0;
  logic    awready;
  logic    awvalid = 1'b0;
  axi_w_t  w = '0;
  logic    wready;
  logic    wvalid = 1'b0;
  axi_b_t  b;
  logic    bready = 1'b0;
  logic    bvalid;
  axi_ar_t ar = '0;
  logic    arready;
  logic    arvalid = 1'b0;
  axi_r_t  r;
  logic    rready = 1'b0;
  logic    rvalid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int aw_edge, ar_edge;

  logic [63:0] got_data [8];
  logic [1:0]  got_resp [8];
  logic        got_last [8];
  logic [3:0]  got_id   [8];

  axi_mem_sub #(
    .DEPTH        (DEPTH),
    .READ_LATENCY (READ_LATENCY),
    .INIT_ZERO    (1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_axi_s_aw      (aw),
    .o_axi_s_awready (awready),
    .i_axi_s_awvalid (awvalid),
    .i_axi_s_w       (w),
    .o_axi_s_wready  (wready),
    .i_axi_s_wvalid  (wvalid),
    .o_axi_s_b       (b),
    .i_axi_s_bready  (bready),
    .o_axi_s_bvalid  (bvalid),
    .i_axi_s_ar      (ar),
    .o_axi_s_arready (arready),
    .i_axi_s_arvalid (arvalid),
    .o_axi_s_r       (r),
    .i_axi_s_rready  (rready),
    .o_axi_s_rvalid  (rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Drivers: called #1 after a posedge, return #1 after the handshake edge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    aw = '{id: id, addr: addr, len: len, size: size, burst: burst};
    awvalid = 1'b1;
    for (int t = 0; t < 50 && !awready; t++) begin @(posedge clk); #1; end
    if (!awready) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout awready=%b required 1", awready);
    end
    @(posedge clk); #1;
    aw_edge = cyc;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    ar = '{id: id, addr: addr, len: len, size: size, burst: burst};
    arvalid = 1'b1;
    for (int t = 0; t < 50 && !arready; t++) begin @(posedge clk); #1; end
    if (!arready) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout arready=%b required 1", arready);
    end
    @(posedge clk); #1;
    ar_edge = cyc;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    w = '{id: 4'h0, data: data, strb: strb, last: last};
    wvalid = 1'b1;
    for (int t = 0; t < 50 && !wready; t++) begin @(posedge clk); #1; end
    if (!wready) begin
      n_cmp++; n_err++;
      $display("FAIL w_timeout wready=%b required 1", wready);
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_b(output axi_b_t got);
    bready = 1'b1;
    for (int t = 0; t < 50 && !bvalid; t++) begin @(posedge clk); #1; end
    if (!bvalid) begin
      n_cmp++; n_err++;
      $display("FAIL b_timeout bvalid=%b required 1", bvalid);
    end
    got = b;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Collects n beats with rready following pattern; counts beats that changed while stalled.
  task automatic recv_r(input int n, input logic [7:0] pattern, output int nrx,
                        output int stall_viol, output int first_cyc);
    logic   held = 1'b0;
    axi_r_t held_r = '0;
    nrx = 0; stall_viol = 0; first_cyc = -1;
    for (int t = 0; t < 100 && nrx < n; t++) begin
      rready = pattern[t % 8];
      if (rvalid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (held && (r !== held_r)) stall_viol++;
        if (rready) begin
          got_data[nrx] = r.data;
          got_resp[nrx] = r.resp;
          got_last[nrx] = r.last;
          got_id[nrx]   = r.id;
          nrx++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          held_r = r;
        end
      end
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [63:0] data);
    axi_b_t bg;
    send_aw(4'hF, addr, 8'd0, AXI_BEAT_SIZE, AXI_BURST_INCR);
    send_w(data, 8'hFF, 1'b1);
    wait_b(bg);
  endtask

  task automatic read_word(input logic [31:0] addr, output logic [63:0] data,
                           output logic [1:0] resp);
    int nrx, sv, fc;
    send_ar(4'hE, addr, 8'd0, AXI_BEAT_SIZE, AXI_BURST_INCR);
    recv_r(1, 8'hFF, nrx, sv, fc);
    data = (nrx == 1) ? got_data[0] : 64'hx;
    resp = (nrx == 1) ? got_resp[0] : 2'bx;
  endtask

  task automatic test_reset();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_handshake aw/ar/w/b/r = %b required 00000",
               {awready, arready, wready, bvalid, rvalid});
    end
    n_cmp++;
    if ((b !== '0) || (r !== '0)) begin
      n_err++;
      $display("FAIL reset_payload b=%h r=%h required 0", b, r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({awready, arready} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_release_early aw/ar ready=%b required 00", {awready, arready});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({awready, arready, bvalid, rvalid} !== 4'b1100) begin
      n_err++;
      $display("FAIL reset_first_edge aw/ar/b/r = %b required 1100",
               {awready, arready, bvalid, rvalid});
    end
  endtask

  task automatic test_single();
    axi_b_t bg;
    int nrx, sv, fc;
    send_aw(4'h3, 32'h18, 8'd0, AXI_BEAT_SIZE, AXI_BURST_INCR);
    send_w(64'h1122334455667788, 8'hFF, 1'b1);
    wait_b(bg);
    n_cmp++;
    if (bg !== '{id: 4'h3, resp: AXI_RESP_OKAY}) begin
      n_err++;
      $display("FAIL single_b got id=%h resp=%b required id=3 resp=00", bg.id, bg.resp);
    end
    send_ar(4'h5, 32'h18, 8'd0, AXI_BEAT_SIZE, AXI_BURST_INCR);
    recv_r(1, 8'hFF, nrx, sv, fc);
    n_cmp++;
    if ((fc - ar_edge) != READ_LATENCY) begin
      n_err++;
      $display("FAIL single_latency got %0d required %0d", fc - ar_edge, READ_LATENCY);
    end
    n_cmp++;
    if ((nrx != 1) || (got_data[0] !== 64'h1122334455667788) || (got_last[0] !== 1'b1) ||
        (got_id[0] !== 4'h5) || (got_resp[0] !== AXI_RESP_OKAY)) begin
      n_err++;
      $display("FAIL single_r got n=%0d data=%h last=%b id=%h resp=%b required 1/1122334455667788/1/5/00",
               nrx, got_data[0], got_last[0], got_id[0], got_resp[0]);
    end
  endtask

  task automatic test_strobe_gap();
    axi_b_t bg;
    logic [63:0] rd;
    logic [1:0]  rs;
    write_word(32'h20, 64'hFFFF_FFFF_FFFF_FFFF);
    send_aw(4'h1, 32'h20, 8'd0, AXI_BEAT_SIZE, AXI_BURST_INCR);
    repeat (7) begin @(posedge clk); #1; end
    n_cmp++;
    if ({wready, bvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL gap_wait wready/bvalid=%b required 10", {wready, bvalid});
    end
    send_w(64'h1122334455667788, 8'h0F, 1'b1);
    wait_b(bg);
    n_cmp++;
    if (bg !== '{id: 4'h1, resp: AXI_RESP_OKAY}) begin
      n_err++;
      $display("FAIL gap_b got id=%h resp=%b required id=1 resp=00", bg.id, bg.resp);
    end
    read_word(32'h20, rd, rs);
    n_cmp++;
    if ((rd !== 64'hFFFFFFFF55667788) || (rs !== AXI_RESP_OKAY)) begin
      n_err++;
      $display("FAIL gap_strobe got %h resp=%b required ffffffff55667788 resp=00", rd, rs);
    end
  endtask

  task automatic test_incr_wrap();
    logic [63:0] exp_d [4];
    axi_b_t bg;
    int nrx, sv, fc;
    logic [63:0] rd;
    logic [1:0]  rs;
    exp_d[0] = 64'hA0A0_0000_0000_1022;
    exp_d[1] = 64'hA1A1_0000_0000_1023;
    exp_d[2] = 64'hA2A2_0000_0000_0000;
    exp_d[3] = 64'hA3A3_0000_0000_0001;
    send_aw(4'h2, 32'h1FF0, 8'd3, AXI_BEAT_SIZE, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++) send_w(exp_d[i], 8'hFF, i == 3);
    wait_b(bg);
    n_cmp++;
    if (bg !== '{id: 4'h2, resp: AXI_RESP_OKAY}) begin
      n_err++;
      $display("FAIL burst_b got id=%h resp=%b required id=2 resp=00", bg.id, bg.resp);
    end
    send_ar(4'h6, 32'h1FF0, 8'd3, AXI_BEAT_SIZE, AXI_BURST_INCR);
    recv_r(4, 8'b1001_0110, nrx, sv, fc);
    n_cmp++;
    if ((nrx != 4) || (sv != 0)) begin
      n_err++;
      $display("FAIL burst_stall got beats=%0d unstable=%0d required 4/0", nrx, sv);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ((got_data[i] !== exp_d[i]) || (got_last[i] !== (i == 3)) || (got_id[i] !== 4'h6)) begin
        n_err++;
        $display("FAIL burst_beat%0d got data=%h last=%b id=%h required %h/%b/6",
                 i, got_data[i], got_last[i], got_id[i], exp_d[i], i == 3);
      end
    end
    read_word(32'h0, rd, rs);
    n_cmp++;
    if (rd !== exp_d[2]) begin
      n_err++;
      $display("FAIL burst_wrap_idx0 got %h required %h", rd, exp_d[2]);
    end
    read_word(32'h8, rd, rs);
    n_cmp++;
    if (rd !== exp_d[3]) begin
      n_err++;
      $display("FAIL burst_wrap_idx1 got %h required %h", rd, exp_d[3]);
    end
  endtask

  task automatic test_collision();
    logic [63:0] rd;
    logic [1:0]  rs;
    write_word(32'h40, 64'hAAAA_BBBB_CCCC_DDDD);
    for (int t = 0; t < 10 && !(awready && arready); t++) begin @(posedge clk); #1; end
    aw = '{id: 4'h4, addr: 32'h40, len: 8'd0, size: AXI_BEAT_SIZE, burst: AXI_BURST_INCR};
    ar = '{id: 4'h7, addr: 32'h40, len: 8'd0, size: AXI_BEAT_SIZE, burst: AXI_BURST_INCR};
    w  = '{id: 4'h4, data: 64'h5555_6666_7777_8888, strb: 8'hFF, last: 1'b1};
    awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1;
    n_cmp++;
    if ({awready, arready, wready} !== 3'b110) begin
      n_err++;
      $display("FAIL coll_idle aw/ar/w ready=%b required 110", {awready, arready, wready});
    end
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    n_cmp++;
    if ((rvalid !== 1'b1) || (r.data !== 64'hAAAA_BBBB_CCCC_DDDD) || (r.id !== 4'h7)) begin
      n_err++;
      $display("FAIL coll_old_data got rvalid=%b data=%h id=%h required 1/aaaabbbbccccdddd/7",
               rvalid, r.data, r.id);
    end
    n_cmp++;
    if ((bvalid !== 1'b1) || (b !== '{id: 4'h4, resp: AXI_RESP_OKAY})) begin
      n_err++;
      $display("FAIL coll_b got bvalid=%b id=%h resp=%b required 1/4/00", bvalid, b.id, b.resp);
    end
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    read_word(32'h40, rd, rs);
    n_cmp++;
    if (rd !== 64'h5555_6666_7777_8888) begin
      n_err++;
      $display("FAIL coll_new_data got %h required 5555666677778888", rd);
    end
  endtask

  task automatic test_illegal();
    axi_b_t bg;
    int nrx, sv, fc;
    logic [63:0] rd;
    logic [1:0]  rs;
    write_word(32'h80, 64'h0123_4567_89AB_CDEF);
    send_aw(4'h9, 32'h80, 8'd0, 3'd2, AXI_BURST_INCR);
    send_w(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 1'b1);
    wait_b(bg);
    n_cmp++;
    if (bg !== '{id: 4'h9, resp: AXI_RESP_SLVERR}) begin
      n_err++;
      $display("FAIL illegal_size_b got id=%h resp=%b required id=9 resp=10", bg.id, bg.resp);
    end
    read_word(32'h80, rd, rs);
    n_cmp++;
    if ((rd !== 64'h0123_4567_89AB_CDEF) || (rs !== AXI_RESP_OKAY)) begin
      n_err++;
      $display("FAIL illegal_mem_kept got %h resp=%b required 0123456789abcdef/00", rd, rs);
    end
    send_ar(4'hA, 32'h80, 8'd1, AXI_BEAT_SIZE, AXI_BURST_WRAP);
    recv_r(2, 8'hFF, nrx, sv, fc);
    n_cmp++;
    if (nrx != 2) begin
      n_err++;
      $display("FAIL illegal_wrap_beats got %0d required 2", nrx);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ((got_resp[i] !== AXI_RESP_SLVERR) || (got_data[i] !== 64'h0) ||
          (got_last[i] !== (i == 1)) || (got_id[i] !== 4'hA)) begin
        n_err++;
        $display("FAIL illegal_wrap_beat%0d got resp=%b data=%h last=%b id=%h required 10/0/%b/a",
                 i, got_resp[i], got_data[i], got_last[i], got_id[i], i == 1);
      end
    end
    send_aw(4'hB, 32'h100, 8'd1, AXI_BEAT_SIZE, AXI_BURST_INCR);
    send_w(64'h1, 8'hFF, 1'b1);
    wait_b(bg);
    n_cmp++;
    if (bg !== '{id: 4'hB, resp: AXI_RESP_SLVERR}) begin
      n_err++;
      $display("FAIL early_wlast_b got id=%h resp=%b required id=b resp=10", bg.id, bg.resp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_strobe_gap();
    test_incr_wrap();
    test_collision();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
